// File: rtl/psum_accum.sv
// Partial-sum accumulator behind the Booth multiplier: seeds from a Q3.12 psum, adds ROW_LEN
// Q3.24 products in two's complement, and returns a rounded, saturated Q3.12 sign-magnitude psum.
module psum_accum #(
  parameter int ROW_LEN = 3,
  parameter int ACC_W   = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psum_in_valid,
  input  logic [15:0] psum_in,
  output logic        psum_ready,
  input  logic        prod_valid,
  input  logic [31:0] prod,
  output logic        prod_ready,
  output logic        out_valid,
  output logic [15:0] out_psum,
  output logic        out_sat,
  input  logic        out_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_LEN - 1);

  // Sign-magnitude (27-bit magnitude) to two's complement; negative zero collapses to zero.
  function automatic logic signed [ACC_W-1:0] sm_to_tc(input logic sgn, input logic [26:0] mag);
    logic signed [ACC_W-1:0] ext;
    ext = $signed({{(ACC_W-27){1'b0}}, mag});
    if (sgn) begin
      return -ext;
    end else begin
      return ext;
    end
  endfunction

  // Q.24 accumulator to {sat, Q3.12 sign-magnitude}, rounding half away from zero.
  function automatic logic [16:0] to_sm16(input logic signed [ACC_W-1:0] a);
    logic              s;
    logic [ACC_W-1:0]  mag;
    logic [ACC_W-1:0]  r;
    logic [14:0]       m;
    logic              sat;
    s   = a[ACC_W-1];
    mag = s ? $unsigned(-a) : $unsigned(a);
    r   = (mag + ACC_W'(2048)) >> 12;
    if (r > ACC_W'(32767)) begin
      m   = 15'h7FFF;
      sat = 1'b1;
    end else begin
      m   = r[14:0];
      sat = 1'b0;
    end
    return {sat, s & (m != 15'd0), m};
  endfunction

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    load_out;
  logic [16:0]             conv;
  logic                    unused_prod_bits;

  assign unused_prod_bits = ^prod[31:28];

  // Ready strobes are pure state decodes so they never depend on same-cycle valids.
  assign psum_ready = (state == IDLE);
  assign prod_ready = (state == ACC);
  assign conv       = to_sm16(acc_nxt);

  // Next-state and accumulator update.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    load_out  = 1'b0;
    case (state)
      IDLE: begin
        if (psum_in_valid) begin
          acc_nxt   = sm_to_tc(psum_in[15], {psum_in[14:0], 12'd0});
          cnt_nxt   = '0;
          state_nxt = ACC;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACC: begin
        if (prod_valid) begin
          acc_nxt = acc + sm_to_tc(prod[27], prod[26:0]);
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt == LAST) begin
            load_out  = 1'b1;
            state_nxt = OUT;
          end else begin
            state_nxt = ACC;
          end
        end else begin
          state_nxt = ACC;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = OUT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, counter and held result; the result is frozen until the output handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_psum  <= 16'h0000;
      out_sat   <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      if (load_out) begin
        out_valid <= 1'b1;
        out_psum  <= conv[15:0];
        out_sat   <= conv[16];
      end else if ((state == OUT) && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed self-checking bench for psum_accum (ROW_LEN=3) with hand-computed expected results.
module tb_psum_accum;

  logic        clk;
  logic        rst;
  logic        psum_in_valid;
  logic [15:0] psum_in;
  logic        psum_ready;
  logic        prod_valid;
  logic [31:0] prod;
  logic        prod_ready;
  logic        out_valid;
  logic [15:0] out_psum;
  logic        out_sat;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  psum_accum #(.ROW_LEN(3), .ACC_W(36)) dut (
    .clk          (clk),
    .rst          (rst),
    .psum_in_valid(psum_in_valid),
    .psum_in      (psum_in),
    .psum_ready   (psum_ready),
    .prod_valid   (prod_valid),
    .prod         (prod),
    .prod_ready   (prod_ready),
    .out_valid    (out_valid),
    .out_psum     (out_psum),
    .out_sat      (out_sat),
    .out_ready    (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_seed(input logic [15:0] v);
    int n;
    n = 0;
    psum_in       = v;
    psum_in_valid = 1'b1;
    while (!psum_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("seed_wait", 32'(psum_ready), 32'd1);
    @(posedge clk);
    #1;
    psum_in_valid = 1'b0;
  endtask

  task automatic send_prod(input logic [31:0] p);
    int n;
    n = 0;
    prod       = p;
    prod_valid = 1'b1;
    while (!prod_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("prod_wait", 32'(prod_ready), 32'd1);
    @(posedge clk);
    #1;
    prod_valid = 1'b0;
  endtask

  // Full row; leaves the DUT in OUT with the result checked.
  task automatic run_row(input string tag, input logic [15:0] seed, input logic [31:0] p0,
                         input logic [31:0] p1, input logic [31:0] p2,
                         input logic [15:0] exp_psum, input logic exp_sat);
    send_seed(seed);
    send_prod(p0);
    send_prod(p1);
    check({tag, "_early"}, 32'(out_valid), 32'd0);
    send_prod(p2);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_psum"}, 32'(out_psum), 32'(exp_psum));
    check({tag, "_sat"}, 32'(out_sat), 32'(exp_sat));
  endtask

  task automatic finish_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vfall"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(psum_ready), 32'd1);
  endtask

  initial begin
    rst           = 1'b0;
    psum_in_valid = 1'b0;
    psum_in       = 16'h0000;
    prod_valid    = 1'b0;
    prod          = 32'h0000_0000;
    out_ready     = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_psum_ready", 32'(psum_ready), 32'd1);
    check("rst_prod_ready", 32'(prod_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_psum", 32'(out_psum), 32'h0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_row("basic", 16'h0000, 32'h06F9_0000, 32'h0, 32'h0, 16'h6F90, 1'b0);
    finish_out("basic");
    run_row("cancel", 16'h6F90, 32'h0EF9_0000, 32'h0, 32'h0, 16'h0000, 1'b0);
    finish_out("cancel");
    run_row("sat_pos", 16'h7000, 32'h06F9_0000, 32'h06F9_0000, 32'h06F9_0000, 16'h7FFF, 1'b1);
    finish_out("sat_pos");
    run_row("sat_neg", 16'hF000, 32'h0EF9_0000, 32'h0EF9_0000, 32'h0EF9_0000, 16'hFFFF, 1'b1);
    finish_out("sat_neg");
    run_row("rnd_up", 16'h0000, 32'h0000_0800, 32'h0, 32'h0, 16'h0001, 1'b0);
    finish_out("rnd_up");
    run_row("rnd_neg", 16'h0000, 32'h0800_0800, 32'h0, 32'h0, 16'h8001, 1'b0);
    finish_out("rnd_neg");
    run_row("rnd_down", 16'h0000, 32'h0000_07FF, 32'h0, 32'h0, 16'h0000, 1'b0);
    finish_out("rnd_down");

    // Backpressure: products and a seed are offered while the result is held.
    run_row("bp", 16'h0000, 32'h06F9_0000, 32'h0, 32'h0, 16'h6F90, 1'b0);
    prod          = 32'h07FF_FFFF;
    prod_valid    = 1'b1;
    psum_in       = 16'h1234;
    psum_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_psum", 32'(out_psum), 32'h6F90);
      check("bp_sat", 32'(out_sat), 32'd0);
      check("bp_prod_ready", 32'(prod_ready), 32'd0);
      check("bp_psum_ready", 32'(psum_ready), 32'd0);
    end
    finish_out("bp");
    psum_in_valid = 1'b0;
    prod_valid    = 1'b0;
    run_row("after_bp", 16'h0000, 32'h06F9_0000, 32'h0, 32'h0, 16'h6F90, 1'b0);
    finish_out("after_bp");

    // Asynchronous reset after two products of a row.
    run_row("pre_rst", 16'h0000, 32'h0000_0800, 32'h0, 32'h0, 16'h0001, 1'b0);
    finish_out("pre_rst");
    send_seed(16'h0000);
    send_prod(32'h06F9_0000);
    send_prod(32'h06F9_0000);
    #2 rst = 1'b1;
    #1;
    check("arst_psum_ready", 32'(psum_ready), 32'd1);
    check("arst_prod_ready", 32'(prod_ready), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_psum", 32'(out_psum), 32'h0);
    check("arst_out_sat", 32'(out_sat), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_row("post_rst", 16'h0000, 32'h06F9_0000, 32'h0, 32'h0, 16'h6F90, 1'b0);
    finish_out("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
Name: psum_accum

Overview:
- Accumulates partial sums in the PE datapath, directly downstream of the Booth multiplier (booth_top).
- Takes a seed psum, then ROW_LEN signed products from the multiplier, and accumulates them in two's complement.
- Returns one rounded, saturated 16-bit sign-magnitude Q3.12 psum over a valid/ready handshake, for the psum scratchpad or the neighbouring PE.

Parameters:
- ROW_LEN, 3: products accumulated per psum. Legal range 1..16.
- ACC_W, 36: internal accumulator width in bits, two's complement, Q.24 scaling.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- psum_in_valid  in  1  seed psum valid.
- psum_in  in  16  seed psum, sign-magnitude Q3.12: [15] sign, [14:0] magnitude.
- psum_ready  out  1  seed accepted this cycle when high together with psum_in_valid.
- prod_valid  in  1  product valid.
- prod  in  32  multiplier product: [27] sign, [26:0] magnitude Q3.24; [31:28] ignored.
- prod_ready  out  1  product accepted this cycle when high together with prod_valid.
- out_valid  out  1  result valid.
- out_psum  out  16  result, sign-magnitude Q3.12.
- out_sat  out  1  result was saturated.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; acc=0; cnt=0; out_valid=0; out_psum=0; out_sat=0; prod_ready=0; psum_ready=1 (decoded from IDLE).
- Handshake: ready signals are decoded from state only and never depend on the same-cycle valid.
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - psum_ready=1.
  - On psum_in_valid: acc <= sign-extended (±psum_in[14:0] << 12); cnt <= 0; go to ACC.
- ACC:
  - prod_ready=1.
  - On prod_valid: acc <= acc + sext(±prod[26:0]); cnt <= cnt+1.
  - When the accepted product is number ROW_LEN (cnt==ROW_LEN-1), load the output registers and go to OUT.
  - With ROW_LEN=1, the first product moves the FSM to OUT.
- OUT:
  - out_valid=1; out_psum and out_sat are registered and held stable until the handshake.
  - prod_ready=0 and psum_ready=0.
  - On out_ready: go to IDLE, out_valid falls next cycle.
  - A seed is not accepted in the same cycle as the output handshake (one bubble cycle).
- Latency: out_valid rises on the clock edge that accepts the last product, so it is visible the cycle after the last product handshake.
- Output conversion (computed from the post-update acc value):
  - s = acc[ACC_W-1]; mag = |acc|.
  - r = (mag + 2^11) >> 12, i.e. round half away from zero.
  - If r > 32767: magnitude = 0x7FFF and out_sat=1; otherwise magnitude = r[14:0] and out_sat=0.
  - out_psum = {s & (magnitude != 0), magnitude}, so negative zero is normalised to 0x0000.
- Width rule: acc never wraps for legal ROW_LEN. The worst case is 2^27 + 16·2^27 < 2^35, so it fits in ACC_W=36.
- Sign-magnitude inputs with magnitude 0 and sign 1 are treated as 0.
- Reset mid-operation returns the block to the reset values immediately. Any partial accumulation is discarded.
- prod_valid while in IDLE or OUT is ignored; the upstream must hold it.

Test Plan:
1. ROW_LEN=3; seed 0x0000; products 0x06F90000, 0x00000000, 0x00000000 -> one cycle after the third product, out_valid=1, out_psum=0x6F90, out_sat=0.
2. Seed 0x6F90; products 0x0EF90000, 0, 0 -> out_psum=0x0000 (not 0x8000), out_sat=0.
3. Seed 0x7000; products 0x06F90000 x3 -> out_psum=0x7FFF, out_sat=1. Same inputs with the seed and product sign bits set -> out_psum=0xFFFF, out_sat=1.
4. Rounding, seed 0x0000:
   - Products 0x00000800, 0, 0 -> out_psum=0x0001.
   - Products 0x08000800, 0, 0 -> out_psum=0x8001.
   - Products 0x000007FF, 0, 0 -> out_psum=0x0000.
5. Backpressure: hold out_ready=0 for 5 cycles in OUT -> out_valid, out_psum and out_sat stable; prod_ready=0 and psum_ready=0 throughout. Products offered during this time are not consumed. After out_ready=1, psum_ready=1 on the following cycle.
6. Assert rst asynchronously after 2 products of a row -> all outputs at reset values on the same edge. The next full row from test 1 yields 0x6F90 with no residue from the aborted row.
